uart_tx_serializer: RTL and testbench

- UART transmitter that sits directly downstream of the MIPS core's output data path.
- Accepts bytes from the processor side through a one-entry holding register and serializes them as 8-bit frames on a single line, LSB first, optional parity.
- Companion to the core's serial receive path; shares the 50 MHz system clock.
- Double buffering lets software queue the next byte while the current frame shifts out.

---
 rtl/uart_tx_serializer_if.sv | 29 ++
 rtl/uart_tx_serializer.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Processor-side write channel of the UART transmitter.
//   tx_data     : byte to transmit (master -> slave)
//   tx_start    : single-cycle write strobe for tx_data (master -> slave)
//   clr_overrun : synchronous clear of the overrun flag (master -> slave)
//   tx_ready    : holding register empty, a write is accepted this cycle (slave -> master)
//   overrun     : sticky flag, a write was dropped (slave -> master)
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       clr_overrun;
    logic       tx_ready;
    logic       overrun;

    modport master (
        output tx_data,
        output tx_start,
        output clr_overrun,
        input  tx_ready,
        input  overrun
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        input  clr_overrun,
        output tx_ready,
        output overrun
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Double-buffered UART transmitter: 8 data bits LSB first, optional parity, one stop bit.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   enable        : 1 = baud counter and FSM advance, 0 = freeze in place
//   wr            : write channel (tx_data, tx_start, clr_overrun, tx_ready, overrun)
//   tx_busy       : a frame is on the line
//   tx_done       : one-cycle pulse at the end of each stop bit
//   SerialDataOut : serial line, idle high
module uart_tx_serializer #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned BAUD_DIV   = CLK_FREQ / BAUD_RATE,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    uart_tx_serializer_if.slave        wr,
    output logic                       tx_busy,
    output logic                       tx_done,
    output logic                       SerialDataOut
);

    localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;
    logic            ready_q;
    logic            overrun_q, overrun_d;
    logic            line_q, line_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic bit_tick;
    logic load;
    logic write;
    logic drop;

    assign bit_tick = enable && (cnt_q == CntMax);
    assign write    = wr.tx_start && ready_q;
    assign drop     = wr.tx_start && !ready_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;

        if (enable && (state_q != StIdle)) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (hold_valid_q && enable) begin
                    state_d = StStart;
                    load    = 1'b1;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    // Pending byte chains straight into the next start bit.
                    if (hold_valid_q) begin
                        state_d = StStart;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d = hold_q;
            par_d   = (^hold_q) ^ PARITY_ODD;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end
    end

    // Outputs, computed from the next state so they register in step with it
    always_comb begin
        done_d = (state_q == StStop) && bit_tick;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_d[0];
            StParity: line_d = par_d;
            default:  line_d = 1'b1;
        endcase
    end

    // Holding register and overrun
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        // load and write never coincide: a write needs an empty hold, a load a full one.
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (write) begin
            hold_d       = wr.tx_data;
            hold_valid_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (wr.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            overrun_q    <= 1'b0;
            line_q       <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= !hold_valid_d;
            overrun_q    <= overrun_d;
            line_q       <= line_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign wr.tx_ready    = ready_q;
    assign wr.overrun     = overrun_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign SerialDataOut  = line_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no parity, even, odd) share one stimulus.
// A frame-level model checks every output of every instance each cycle; directed
// literal checks pin the model on the no-parity instance and the parity bits.
module tb_uart_tx_serializer;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       start;
    logic       clr;
    logic [7:0] data;

    logic [2:0] line_w, done_w, busy_w, ready_w, ovr_w;

    uart_tx_serializer_if bus0 ();
    uart_tx_serializer_if bus1 ();
    uart_tx_serializer_if bus2 ();

    assign bus0.tx_data = data;  assign bus0.tx_start = start;  assign bus0.clr_overrun = clr;
    assign bus1.tx_data = data;  assign bus1.tx_start = start;  assign bus1.clr_overrun = clr;
    assign bus2.tx_data = data;  assign bus2.tx_start = start;  assign bus2.clr_overrun = clr;

    assign ready_w = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
    assign ovr_w   = {bus2.overrun, bus1.overrun, bus0.overrun};

    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .enable(en), .wr(bus0),
        .tx_busy(busy_w[0]), .tx_done(done_w[0]), .SerialDataOut(line_w[0])
    );
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .reset(rst_n), .enable(en), .wr(bus1),
        .tx_busy(busy_w[1]), .tx_done(done_w[1]), .SerialDataOut(line_w[1])
    );
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .reset(rst_n), .enable(en), .wr(bus2),
        .tx_busy(busy_w[2]), .tx_done(done_w[2]), .SerialDataOut(line_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit         m_hv[3], m_ovr[3], m_ready[3], m_busy[3], m_done[3], m_line[3], m_active[3];
    logic [7:0] m_hold[3];
    bit         m_frame[3][11];
    int         m_nbits[3], m_pos[3];

    function automatic bit pen(input int k);
        return k != 0;
    endfunction

    function automatic bit pod(input int k);
        return k == 2;
    endfunction

    task automatic model_step(input int k);
        bit w, d, hv_pre, p;
        if (!rst_n) begin
            m_hv[k] = 0; m_ovr[k] = 0; m_ready[k] = 1; m_busy[k] = 0; m_done[k] = 0;
            m_line[k] = 1; m_active[k] = 0; m_hold[k] = 8'h00; m_pos[k] = 0; m_nbits[k] = 10;
            return;
        end
        w = start && m_ready[k];
        d = start && !m_ready[k];
        hv_pre = m_hv[k];
        m_done[k] = 0;
        if (m_active[k] && en) begin
            m_pos[k]++;
            if (m_pos[k] >= m_nbits[k] * DIV) begin
                m_active[k] = 0;
                m_done[k] = 1;
            end
        end
        if (!m_active[k] && hv_pre && en) begin
            m_frame[k][0] = 0;
            for (int b = 0; b < 8; b++) m_frame[k][b + 1] = m_hold[k][b];
            if (pen(k)) begin
                p = 0;
                for (int b = 0; b < 8; b++) p = p ^ m_hold[k][b];
                m_frame[k][9] = p ^ pod(k);
                m_frame[k][10] = 1;
                m_nbits[k] = 11;
            end else begin
                m_frame[k][9] = 1;
                m_nbits[k] = 10;
            end
            m_hv[k] = 0;
            m_active[k] = 1;
            m_pos[k] = 0;
        end
        if (w) begin
            m_hv[k] = 1;
            m_hold[k] = data;
        end
        if (d) m_ovr[k] = 1;
        else if (clr) m_ovr[k] = 0;
        m_ready[k] = !m_hv[k];
        m_busy[k] = m_active[k];
        m_line[k] = m_active[k] ? m_frame[k][m_pos[k] / DIV] : 1'b1;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d line", k),  line_w[k],  m_line[k]);
            check($sformatf("dut%0d done", k),  done_w[k],  m_done[k]);
            check($sformatf("dut%0d busy", k),  busy_w[k],  m_busy[k]);
            check($sformatf("dut%0d ready", k), ready_w[k], m_ready[k]);
            check($sformatf("dut%0d ovr", k),   ovr_w[k],   m_ovr[k]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        data  = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // 0xA5 frame, one entry per bit slot: start, 1,0,1,0,0,1,0,1, stop
    bit a5_slots[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int busy_cnt;

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; clr = 1'b0; data = 8'h00;
        repeat (2) step();
        check("reset line", line_w, 3'b111);
        check("reset ready", ready_w, 3'b111);
        check("reset busy", busy_w, 3'b000);
        check("reset done", done_w, 3'b000);
        check("reset ovr", ovr_w, 3'b000);
        rst_n = 1'b1;
        repeat (2) step();

        // Frame timing
        send(8'hA5);
        check("a5 ready after write", ready_w[0], 1'b0);
        check("a5 line before load", line_w[0], 1'b1);
        step();
        check("a5 busy at load", busy_w[0], 1'b1);
        check("a5 ready at load", ready_w[0], 1'b1);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("a5 line c%0d", i), line_w[0], a5_slots[i / DIV]);
            step();
        end
        check("a5 done at 40", done_w[0], 1'b1);
        check("a5 busy at 40", busy_w[0], 1'b0);
        step();
        check("a5 done at 41", done_w[0], 1'b0);
        repeat (20) step();

        // Back-to-back
        send(8'h3C);
        step();
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_w[0]) busy_cnt++;
            if (i == 9) check("b2b ready drops", ready_w[0], 1'b0);
            if (i == 39) check("b2b ready still low", ready_w[0], 1'b0);
            if (i == 40) begin
                check("b2b ready at 2nd load", ready_w[0], 1'b1);
                check("b2b 2nd start bit", line_w[0], 1'b0);
                check("b2b done", done_w[0], 1'b1);
                check("b2b busy held", busy_w[0], 1'b1);
            end
            if (i == 44) check("b2b c3 bit0", line_w[0], 1'b1);
            if (i == 8) begin data = 8'hC3; start = 1'b1; end
            if (i == 9) start = 1'b0;
            step();
        end
        check("b2b busy clocks", busy_cnt, 80);

        // Overrun
        send(8'h11);
        step();
        for (int i = 0; i < 100; i++) begin
            if (i == 3) check("ovr hold full", ready_w[0], 1'b0);
            if (i == 4) check("ovr set", ovr_w[0], 1'b1);
            if (i == 5) check("ovr cleared", ovr_w[0], 1'b0);
            if (i == 6) check("ovr set wins", ovr_w[0], 1'b1);
            if (i == 40) check("ovr frame done", done_w[0], 1'b1);
            if (i == 44) check("ovr 0x22 bit0", line_w[0], 1'b0);
            if (i == 48) check("ovr 0x22 bit1", line_w[0], 1'b1);
            if (i == 2) begin data = 8'h22; start = 1'b1; end
            if (i == 3) begin data = 8'hFF; start = 1'b1; end
            if (i == 4) begin start = 1'b0; clr = 1'b1; end
            if (i == 5) begin data = 8'hFF; start = 1'b1; clr = 1'b1; end
            if (i == 6) begin start = 1'b0; clr = 1'b0; end
            step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();

        // Parity
        send(8'h07);
        step();
        for (int i = 0; i < 60; i++) begin
            if (i == 33) check("par bit7 even", line_w[1], 1'b0);
            if (i == 37) begin
                check("par nopar stop", line_w[0], 1'b1);
                check("par even bit", line_w[1], 1'b1);
                check("par odd bit", line_w[2], 1'b0);
            end
            if (i == 40) begin
                check("par nopar done", done_w[0], 1'b1);
                check("par even no done yet", done_w[1], 1'b0);
                check("par even busy", busy_w[1], 1'b1);
            end
            if (i == 44) begin
                check("par even done", done_w[1], 1'b1);
                check("par even busy off", busy_w[1], 1'b0);
                check("par odd done", done_w[2], 1'b1);
            end
            step();
        end

        // Enable stall during data bit 3
        send(8'h08);
        step();
        for (int i = 0; i < 60; i++) begin
            if (i == 15) check("stall bit2", line_w[0], 1'b0);
            if (i == 16) check("stall bit3 start", line_w[0], 1'b1);
            if (i == 20) check("stall bit3 held", line_w[0], 1'b1);
            if (i == 26) check("stall bit3 end", line_w[0], 1'b1);
            if (i == 27) check("stall bit4", line_w[0], 1'b0);
            if (i == 40) check("stall no early done", done_w[0], 1'b0);
            if (i == 47) check("stall done", done_w[0], 1'b1);
            if (i == 17) en = 1'b0;
            if (i == 24) en = 1'b1;
            step();
        end

        // Reset mid-frame during data bit 5
        send(8'h00);
        step();
        for (int i = 0; i < 30; i++) begin
            if (i == 25) begin
                check("rst line low before", line_w[0], 1'b0);
                rst_n = 1'b0;
                #1;
                check("rst async line", line_w, 3'b111);
                check("rst async busy", busy_w, 3'b000);
                check("rst async ready", ready_w, 3'b111);
                check("rst async done", done_w, 3'b000);
                check("rst async ovr", ovr_w, 3'b000);
            end
            if (i == 26) check("rst held line", line_w[0], 1'b1);
            if (i == 27) rst_n = 1'b1;
            step();
        end
        repeat (5) step();
        send(8'h55);
        step();
        for (int i = 0; i < 45; i++) begin
            if (i == 0) check("55 start", line_w[0], 1'b0);
            if (i == 4) check("55 bit0", line_w[0], 1'b1);
            if (i == 8) check("55 bit1", line_w[0], 1'b0);
            if (i == 40) check("55 done", done_w[0], 1'b1);
            step();
        end
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
